// File: rtl/act_line_buffer.sv
// ---------------------------------------------------------------------------
// act_line_buffer
//
// Row buffer for a 3x3 convolution front end. Pixels arrive in raster order.
// Two line memories hold the previous two rows. For every accepted pixel from
// row 2 onward, the block presents one column of the 3x3 window: the pixel
// two rows up, the pixel one row up, and the current pixel. act_load pulses
// once for each such column. patch_valid marks the pulses that complete a full
// 3x3 window, which needs at least three columns of the row.
//
// Parameters
//   DATA_WIDTH  activation word width
//   MAX_WIDTH   maximum row length in pixels (depth of each line memory)
//   DIM_W       width of the dimension ports and the row/column counters
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   start             frame request; honoured only when idle
//   img_width/height  frame dimensions, sampled when start is accepted
//   pix_valid/data    upstream raster pixel stream
//   stall             downstream hold; blocks acceptance in the same cycle
//   pix_ready         high while running and not stalled
//   act_load          shift strobe for the downstream 3x3 patch register
//   data_*_row        window column: rows r-2, r-1 and r
//   patch_valid       act_load that completes a full 3x3 window
//   busy              frame in progress (state is not IDLE)
//   done              one-cycle end-of-frame pulse
//   cfg_err           frame dimensions were illegal (valid with done)
//   stall_cnt         stalled RUN cycles with pix_valid high
//                     (present only when ACT_LB_STALL_CNT_EN is defined)
// ---------------------------------------------------------------------------
module act_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WIDTH  = 224,
  parameter int DIM_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM_W-1:0]      img_width,
  input  logic [DIM_W-1:0]      img_height,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  stall,
  output logic                  pix_ready,
  output logic                  act_load,
  output logic [DATA_WIDTH-1:0] data_first_row,
  output logic [DATA_WIDTH-1:0] data_second_row,
  output logic [DATA_WIDTH-1:0] data_third_row,
  output logic                  patch_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
`ifdef ACT_LB_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] height_q;
  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;

  logic [DATA_WIDTH-1:0] lb0 [MAX_WIDTH];  // row r-2
  logic [DATA_WIDTH-1:0] lb1 [MAX_WIDTH];  // row r-1

  logic          dims_bad;
  logic          start_ok;
  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          row_ge2;
  logic          col_ge2;
  logic [AW-1:0] col_idx;

  // A frame narrower or shorter than the window, or wider than a line memory,
  // cannot be processed; it is reported through done/cfg_err instead.
  assign dims_bad = (img_width  < DIM_W'(3)) ||
                    (img_height < DIM_W'(3)) ||
                    (32'(img_width) > 32'(MAX_WIDTH));

  assign start_ok = (state == S_IDLE) && start;
  assign accept   = pix_valid && pix_ready;
  assign last_col = (col == width_q  - DIM_W'(1));
  assign last_row = (row == height_q - DIM_W'(1));
  assign row_ge2  = (row >= DIM_W'(2));
  assign col_ge2  = (col >= DIM_W'(2));
  assign col_idx  = AW'(col);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values, independent of the order in which always blocks run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_n is given a default before the case statement, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = dims_bad ? S_DONE : S_RUN;
      S_RUN:  if (accept && last_col && last_row) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_RUN: begin
        pix_ready = !stall;
        busy      = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Frame geometry and raster position
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q  <= '0;
      height_q <= '0;
      col      <= '0;
      row      <= '0;
    end else if (start_ok) begin
      width_q  <= img_width;
      height_q <= img_height;
      col      <= '0;
      row      <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

  // Error flag stays visible until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cfg_err <= 1'b0;
    else if (start_ok) cfg_err <= dims_bad;
  end

  // -------------------------------------------------------------------------
  // Window column outputs
  // -------------------------------------------------------------------------
  // Only acceptances from row 2 onward produce a load. Restricting the update
  // to those keeps the row outputs stable whenever act_load is low, and means
  // the line memories are read only after the current frame has filled them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_load        <= 1'b0;
      patch_valid     <= 1'b0;
      data_first_row  <= '0;
      data_second_row <= '0;
      data_third_row  <= '0;
    end else begin
      act_load    <= accept && row_ge2;
      patch_valid <= accept && row_ge2 && col_ge2;
      if (accept && row_ge2) begin
        data_first_row  <= lb0[col_idx];
        data_second_row <= lb1[col_idx];
        data_third_row  <= pix_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Line memories
  // -------------------------------------------------------------------------
  // NOTE: the memories have no reset; clearing every word would prevent RAM
  // inference, and no word is read in a frame before that frame writes it.
  // Each accepted pixel shifts its column down one row: LB1 -> LB0, pixel ->
  // LB1. In row 0, LB1 has not been written yet this frame, so LB0 is left
  // alone until row 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (row != '0) lb0[col_idx] <= lb1[col_idx];
      lb1[col_idx] <= pix_data;
    end
  end

`ifdef ACT_LB_STALL_CNT_EN
  // -------------------------------------------------------------------------
  // Backpressure statistics: RUN cycles in which a pixel was offered but
  // stalled. The counter saturates instead of wrapping.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if ((state == S_RUN) && pix_valid && stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_act_line_buffer
//
// Self-checking bench for act_line_buffer. A frame-level model stores each
// whole image in an array. For every accepted pixel at (r, c) with r >= 2,
// the expected window column is image[r-2][c], image[r-1][c], image[r][c].
// Expected ready/busy/done/cfg_err come from the frame bookkeeping: dimensions,
// pixels still outstanding, and the stall input.
// Build with +define+ACT_LB_STALL_CNT_EN to also cover stall_cnt.
// ---------------------------------------------------------------------------
module tb_act_line_buffer;

  localparam int DW   = 16;
  localparam int MW   = 224;
  localparam int DIMW = 8;

  logic            clk        = 1'b0;
  logic            rst_n      = 1'b0;
  logic            start      = 1'b0;
  logic [DIMW-1:0] img_width  = '0;
  logic [DIMW-1:0] img_height = '0;
  logic            pix_valid  = 1'b0;
  logic [DW-1:0]   pix_data   = '0;
  logic            stall      = 1'b0;
  logic            pix_ready;
  logic            act_load;
  logic [DW-1:0]   data_first_row;
  logic [DW-1:0]   data_second_row;
  logic [DW-1:0]   data_third_row;
  logic            patch_valid;
  logic            busy;
  logic            done;
  logic            cfg_err;
`ifdef ACT_LB_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  act_line_buffer #(
    .DATA_WIDTH (DW),
    .MAX_WIDTH  (MW),
    .DIM_W      (DIMW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .img_width       (img_width),
    .img_height      (img_height),
    .pix_valid       (pix_valid),
    .pix_data        (pix_data),
    .stall           (stall),
    .pix_ready       (pix_ready),
    .act_load        (act_load),
    .data_first_row  (data_first_row),
    .data_second_row (data_second_row),
    .data_third_row  (data_third_row),
    .patch_valid     (patch_valid),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err)
`ifdef ACT_LB_STALL_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  // ---------------------------------------------------------------- model
  bit            running;
  bit            m_busy, m_done, m_load, m_pv, m_err;
  int            m_w, m_h, m_k;
  logic [DW-1:0] m_d1, m_d2, m_d3;
  logic [DW-1:0] img [0:2047];
  logic [31:0]   m_scnt;

  // Observed statistics for the directed scenarios.
  int            load_cnt, pv_cnt, done_cnt;
  logic [DW-1:0] fl1, fl2, fl3, ll1, ll2, ll3;
  bit            ll_pv;

  typedef struct {
    logic [DIMW-1:0] w;
    logic [DIMW-1:0] h;
    logic            exp_err;
  } cfg_vec_t;

  cfg_vec_t cfg_tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    load_cnt = 0;
    pv_cnt   = 0;
    done_cnt = 0;
  endtask

  // Compares the outputs for this cycle at the falling edge, then updates
  // the model for the inputs the next rising edge will see.
  task automatic cycle();
    bit n_load, n_pv, n_done, acc;
    int r, c;
    @(negedge clk);
    check("act_load",        32'(act_load),        32'(m_load));
    check("patch_valid",     32'(patch_valid),     32'(m_pv));
    check("data_first_row",  32'(data_first_row),  32'(m_d1));
    check("data_second_row", 32'(data_second_row), 32'(m_d2));
    check("data_third_row",  32'(data_third_row),  32'(m_d3));
    check("busy",            32'(busy),            32'(m_busy));
    check("done",            32'(done),            32'(m_done));
    check("cfg_err",         32'(cfg_err),         32'(m_err));
    check("pix_ready",       32'(pix_ready),       32'(running && !stall));
`ifdef ACT_LB_STALL_CNT_EN
    check("stall_cnt",       stall_cnt,            m_scnt);
`endif
    if (act_load) begin
      load_cnt++;
      if (patch_valid) pv_cnt++;
      if (load_cnt == 1) begin
        fl1 = data_first_row; fl2 = data_second_row; fl3 = data_third_row;
      end
      ll1 = data_first_row; ll2 = data_second_row; ll3 = data_third_row;
      ll_pv = patch_valid;
    end
    if (done) done_cnt++;

    n_load = 0; n_pv = 0; n_done = 0;
    acc = running && !stall && pix_valid;
    if (running && pix_valid && stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    if (!m_busy && start) begin
      m_err  = (int'(img_width) < 3) || (int'(img_height) < 3) || (int'(img_width) > MW);
      m_scnt = 0;
      if (m_err) n_done = 1;
      else begin
        running = 1; m_w = int'(img_width); m_h = int'(img_height); m_k = 0;
      end
    end else if (acc) begin
      r = m_k / m_w;
      c = m_k % m_w;
      img[m_k] = pix_data;
      if (r >= 2) begin
        n_load = 1;
        n_pv   = (c >= 2);
        m_d1   = img[(r-2)*m_w + c];
        m_d2   = img[(r-1)*m_w + c];
        m_d3   = pix_data;
      end
      m_k++;
      if (m_k == m_w * m_h) begin
        running = 0;
        n_done  = 1;
      end
    end
    @(posedge clk);
    #1;
    m_load = n_load;
    m_pv   = n_pv;
    m_done = n_done;
    m_busy = running || n_done;
  endtask

  // Asynchronous reset: outputs must be zero while rst_n is low, before any
  // clock edge has occurred.
  task automatic do_reset();
    start = 0; pix_valid = 0; stall = 0;
    rst_n = 0;
    #2;
    check("rst_act_load",    32'(act_load),        0);
    check("rst_patch_valid", 32'(patch_valid),     0);
    check("rst_first_row",   32'(data_first_row),  0);
    check("rst_second_row",  32'(data_second_row), 0);
    check("rst_third_row",   32'(data_third_row),  0);
    check("rst_busy",        32'(busy),            0);
    check("rst_done",        32'(done),            0);
    check("rst_cfg_err",     32'(cfg_err),         0);
    check("rst_pix_ready",   32'(pix_ready),       0);
`ifdef ACT_LB_STALL_CNT_EN
    check("rst_stall_cnt",   stall_cnt,            0);
`endif
    running = 0; m_busy = 0; m_done = 0; m_load = 0; m_pv = 0; m_err = 0;
    m_d1 = 0; m_d2 = 0; m_d3 = 0; m_scnt = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: sequential data base+k, valid always, no random stall
  // mode 2: random data, random valid, random stall, random (ignored) start
  task automatic run_frame(input int w, input int h, input int mode, input int base,
                           input int stall_at, input int stall_len, input int reset_after);
    int budget, held;
    img_width = DIMW'(w); img_height = DIMW'(h); start = 1;
    cycle();
    start  = 0;
    budget = w * h * 10 + 50;
    held   = 0;
    while (running && budget > 0) begin
      if (reset_after >= 0 && m_k == reset_after) begin
        do_reset();
        return;
      end
      if (mode == 2) begin
        pix_valid = ($urandom_range(0, 3) != 0);
        pix_data  = DW'($urandom);
        stall     = ($urandom_range(0, 4) == 0);
        start     = ($urandom_range(0, 9) == 0);
      end else begin
        pix_valid = 1;
        pix_data  = DW'(base + m_k);
        stall     = 0;
      end
      if (stall_at >= 0 && m_k == stall_at && held < stall_len) begin
        stall = 1;
        held++;
      end
      cycle();
      budget--;
    end
    if (running) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=%0d pixels required=%0d", m_k, w * h);
    end
    pix_valid = 0; stall = 0; start = 0;
    repeat (3) cycle();
  endtask

  task automatic check_4x4_result(input string tag);
    check({tag, "_loads"},      load_cnt,   8);
    check({tag, "_patches"},    pv_cnt,     4);
    check({tag, "_first_row0"}, 32'(fl1),   0);
    check({tag, "_first_row1"}, 32'(fl2),   4);
    check({tag, "_first_row2"}, 32'(fl3),   8);
    check({tag, "_done_cnt"},   done_cnt,   1);
  endtask

  initial begin
    cfg_tbl[0] = '{w: 8'd2,   h: 8'd4,   exp_err: 1'b1};
    cfg_tbl[1] = '{w: 8'd4,   h: 8'd2,   exp_err: 1'b1};
    cfg_tbl[2] = '{w: 8'd0,   h: 8'd0,   exp_err: 1'b1};
    cfg_tbl[3] = '{w: 8'd225, h: 8'd5,   exp_err: 1'b1};
    cfg_tbl[4] = '{w: 8'd3,   h: 8'd3,   exp_err: 1'b0};
    cfg_tbl[5] = '{w: 8'd224, h: 8'd200, exp_err: 1'b0};

    @(posedge clk);
    #1;
    do_reset();
    repeat (2) cycle();

    // 4x4 frame, pixels 0..15, no stall.
    clear_stats();
    run_frame(4, 4, 0, 0, -1, 0, -1);
    check_4x4_result("f4x4");

    // 3x3 frame, pixels 1..9: the last load is the only full window.
    clear_stats();
    run_frame(3, 3, 0, 1, -1, 0, -1);
    check("f3x3_last_row0", 32'(ll1), 3);
    check("f3x3_last_row1", 32'(ll2), 6);
    check("f3x3_last_row2", 32'(ll3), 9);
    check("f3x3_last_pv",   32'(ll_pv), 1);
    check("f3x3_busy_after", 32'(busy), 0);

    // Stall held for 5 cycles in the middle of row 2.
    clear_stats();
    run_frame(4, 4, 0, 0, 9, 5, -1);
    check_4x4_result("stall");
`ifdef ACT_LB_STALL_CNT_EN
    check("stall_cnt_5", stall_cnt, 5);
`endif

    // Dimension table: illegal sizes give done+cfg_err on the next cycle.
    for (int i = 0; i < 6; i++) begin
      img_width = cfg_tbl[i].w; img_height = cfg_tbl[i].h; start = 1;
      cycle();
      start = 0;
      check("tbl_done",    32'(done),      32'(cfg_tbl[i].exp_err));
      check("tbl_cfg_err", 32'(cfg_err),   32'(cfg_tbl[i].exp_err));
      check("tbl_ready",   32'(pix_ready), 32'(!cfg_tbl[i].exp_err));
      if (cfg_tbl[i].exp_err) repeat (2) cycle();
      else do_reset();
    end

    // Reset after 6 pixels, then a clean 4x4 frame.
    clear_stats();
    run_frame(4, 4, 0, 0, -1, 0, 6);
    repeat (2) cycle();
    clear_stats();
    run_frame(4, 4, 0, 0, -1, 0, -1);
    check_4x4_result("after_rst");

    // Widest legal row.
    run_frame(MW, 3, 2, 0, -1, 0, -1);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(3, 9), $urandom_range(3, 6), 2, 0, -1, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_line_buffer.md
ACT_LINE_BUFFER -- requirements
Module: act_line_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, activation word width.
REQ-002 Parameter MAX_WIDTH, default 224, maximum image row length in pixels.
REQ-003 Parameter DIM_W, default 8, width of dimension ports and counters.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-007 img_width  input  DIM_W  row length W; sampled when start is accepted.
REQ-008 img_height  input  DIM_W  row count H; sampled when start is accepted.
REQ-009 pix_valid  input  1  upstream pixel valid, raster order.
REQ-010 pix_data  input  DATA_WIDTH  upstream pixel.
REQ-011 stall  input  1  downstream hold request; blocks acceptance.
REQ-012 pix_ready  output  1  high when state is RUN and stall is low.
REQ-013 act_load  output  1  shift strobe for the downstream 3x3 patch register.
REQ-014 data_first_row  output  DATA_WIDTH  pixel from row r-2 at the current column.
REQ-015 data_second_row  output  DATA_WIDTH  pixel from row r-1 at the current column.
REQ-016 data_third_row  output  DATA_WIDTH  pixel from row r at the current column.
REQ-017 patch_valid  output  1  high with act_load when the load completes a full 3x3 window.
REQ-018 busy  output  1  high when state is not IDLE.
REQ-019 done  output  1  one-cycle end-of-frame pulse.
REQ-020 cfg_err  output  1  valid with done; set when the frame dimensions are illegal.

Function
REQ-021 The FSM SHALL have states IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-022 In IDLE, start SHALL latch W and H, clear col and row to 0, and enter RUN; if W<3, H<3 or W>MAX_WIDTH, it SHALL instead enter DONE with cfg_err=1 and accept no pixels.
REQ-023 A pixel SHALL be accepted when pix_valid and pix_ready are both high.
REQ-024 The block SHALL hold two line memories, LB0 (row r-2) and LB1 (row r-1), each MAX_WIDTH deep.
REQ-025 On acceptance at column c: next-cycle data_first_row=LB0[c], data_second_row=LB1[c], data_third_row=pix_data; then LB0[c] is written with LB1[c] and LB1[c] with pix_data.
REQ-026 act_load SHALL be registered, high exactly one cycle after each acceptance with row>=2, and low otherwise; latency is 1 cycle.
REQ-027 patch_valid SHALL equal act_load AND (col>=2) for the accepted pixel.
REQ-028 Row outputs SHALL hold their value when act_load is low.
REQ-029 col SHALL wrap from W-1 to 0 and increment row; acceptance of (H-1, W-1) SHALL enter DONE.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE; cfg_err SHALL clear on the next start.
REQ-031 start SHALL be ignored in RUN and DONE; stall SHALL be honoured in the same cycle, with no acceptance and no act_load one cycle later.

Reset
REQ-032 Assertion of rst_n low, including mid-frame, SHALL immediately force IDLE, clear col and row, and zero all outputs; line memory contents are not reset and are never read before they are written in a frame.

Configuration
REQ-033 When ACT_LB_STALL_CNT_EN is defined, a 32-bit output stall_cnt SHALL count RUN cycles with pix_valid=1 and stall=1, clear on start and reset, and saturate at all-ones; without the macro, the port and counter SHALL be absent.

Verification
REQ-034 W=4, H=4, pixels 0..15, no stall -> 8 act_load pulses; the first has rows (0,4,8); patch_valid is high on 4 pulses; done pulses once, cycles after pixel 15 accepted.
REQ-035 W=3, H=3, pixels 1..9 -> final load carries (3,6,9) with patch_valid=1; busy is low after done.
REQ-036 stall held 5 cycles mid-row -> pix_ready low, no act_load, outputs unchanged; resumes with no lost or duplicated pixel; stall_cnt=5 when the macro is defined.
REQ-037 start with W=2 -> done and cfg_err high on the next cycle, pix_ready never high.
REQ-038 rst_n low after 6 pixels of a 4x4 frame -> IDLE, all outputs 0; a new 4x4 frame then produces the output of REQ-034 exactly.
